// File: rtl/mc_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_if : instruction/flag/handshake inputs and datapath control bundle   |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface mc_ctrl_if #(
  parameter int INSTR_W    = 16,
  parameter int ALU_CTRL_W = 2
);
  logic [INSTR_W-1:0]    Instr;
  logic [3:0]            ALUFlags;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  MemWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [3:0]            Flags;

  // master: the controller; slave: the datapath side
  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_controller : multicycle controller, FSM sequencing 2-5 cycles/instruction |
// | Option macro  : MC_CTRL_CONDSKIP_EN (failed condition returns to FETCH early) |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module mc_controller #(
  parameter int INSTR_W    = 16,
  parameter int RD_LSB     = 0,
  parameter int PC_REG     = 15,
  parameter int ALU_CTRL_W = 2
) (
  input wire        clk,
  input wire        reset,
  mc_ctrl_if.master bus
);
  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_ORR = 2'b11;
  localparam logic [1:0] c_OP_DP   = 2'b00;
  localparam logic [1:0] c_OP_MEM  = 2'b01;
  localparam logic [1:0] c_OP_B    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR,
    S_MEMWB, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t             r_state, w_next;
  logic [3:0]         r_flags;
  logic               r_cond_ok;

  logic [INSTR_W-1:0] w_instr;
  logic [3:0]         w_cond, w_rd, w_cmd;
  logic [1:0]         w_op;
  logic [5:0]         w_funct;
  logic [1:0]         w_dp_alu;
  logic               w_dp_regw, w_arith, w_s;
  logic               w_regw, w_rd_is_pc, w_cond_pass, w_skip;
  logic [1:0]         w_flagw;
  logic               w_n, w_z, w_c, w_v;
  logic               w_unused;

  assign w_instr  = bus.Instr;
  assign w_cond   = w_instr[INSTR_W-1 -: 4];
  assign w_op     = w_instr[INSTR_W-5 -: 2];
  assign w_funct  = w_instr[INSTR_W-7 -: 6];
  assign w_rd     = w_instr[RD_LSB +: 4];
  assign w_cmd    = w_funct[4:1];
  assign w_unused = ^w_instr;

  always_comb begin
    w_dp_alu  = c_ALU_ADD;
    w_dp_regw = 1'b0;
    w_arith   = 1'b0;
    w_s       = w_funct[0];
    case (w_cmd)
      4'b0100: begin w_dp_alu = c_ALU_ADD; w_dp_regw = 1'b1; w_arith = 1'b1; end
      4'b0010: begin w_dp_alu = c_ALU_SUB; w_dp_regw = 1'b1; w_arith = 1'b1; end
      4'b0000: begin w_dp_alu = c_ALU_AND; w_dp_regw = 1'b1; end
      4'b1100: begin w_dp_alu = c_ALU_ORR; w_dp_regw = 1'b1; end
      4'b1010: begin w_dp_alu = c_ALU_SUB; w_arith = 1'b1; w_s = 1'b1; end
      default: ;
    endcase
  end

  // Loads write the register file; stores and branches never do.
  assign w_regw     = (w_op == c_OP_DP)  ? w_dp_regw :
                      (w_op == c_OP_MEM) ? w_funct[0] : 1'b0;
  assign w_flagw    = (w_op == c_OP_DP) ? {w_s, w_s & w_arith} : 2'b00;
  assign w_rd_is_pc = (w_rd == 4'(PC_REG));

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_pass = 1'b0;
    case (w_cond)
      4'h0: w_cond_pass = w_z;
      4'h1: w_cond_pass = ~w_z;
      4'h2: w_cond_pass = w_c;
      4'h3: w_cond_pass = ~w_c;
      4'h4: w_cond_pass = w_n;
      4'h5: w_cond_pass = ~w_n;
      4'h6: w_cond_pass = w_v;
      4'h7: w_cond_pass = ~w_v;
      4'h8: w_cond_pass = w_c & ~w_z;
      4'h9: w_cond_pass = ~w_c | w_z;
      4'hA: w_cond_pass = (w_n == w_v);
      4'hB: w_cond_pass = (w_n != w_v);
      4'hC: w_cond_pass = ~w_z & (w_n == w_v);
      4'hD: w_cond_pass = w_z | (w_n != w_v);
      4'hE: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

`ifdef MC_CTRL_CONDSKIP_EN
  assign w_skip = ~w_cond_pass;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_flags   <= 4'h0;
      r_cond_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_cond_ok <= w_cond_pass;
      if ((r_state == S_EXECR || r_state == S_EXECI) && r_cond_ok) begin
        if (w_flagw[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
        if (w_flagw[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  logic       w_pcw, w_irw, w_mw, w_rw, w_adr, w_srca;
  logic [1:0] w_rsrc, w_srcb, w_alu;

  always_comb begin
    w_next = r_state;
    w_pcw  = 1'b0;
    w_irw  = 1'b0;
    w_mw   = 1'b0;
    w_rw   = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_srcb = 2'b00;
    w_rsrc = 2'b00;
    w_alu  = c_ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw  = bus.MemReady;
        w_pcw  = bus.MemReady;
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_rsrc = 2'b10;
        if (bus.MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        if (w_skip)                  w_next = S_FETCH;
        else if (w_op == c_OP_DP)    w_next = w_funct[5] ? S_EXECI : S_EXECR;
        else if (w_op == c_OP_MEM)   w_next = S_MEMADR;
        else if (w_op == c_OP_B)     w_next = S_BRANCH;
        else                         w_next = S_FETCH;
      end
      S_MEMADR: begin
        w_srcb = 2'b01;
        w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr = 1'b1;
        if (bus.MemReady) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_adr = 1'b1;
        w_mw  = r_cond_ok & bus.MemReady;
        if (bus.MemReady) w_next = S_FETCH;
      end
      S_MEMWB, S_ALUWB: begin
        w_rsrc = (r_state == S_MEMWB) ? 2'b01 : 2'b00;
        w_rw   = r_cond_ok & w_regw;
        w_pcw  = r_cond_ok & w_regw & w_rd_is_pc;
        w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_srcb = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu  = w_dp_alu;
        w_next = S_ALUWB;
      end
      S_BRANCH: begin
        w_srcb = 2'b01;
        w_rsrc = 2'b10;
        w_pcw  = r_cond_ok;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are held low for the whole time reset is asserted.
  assign bus.PCWrite    = w_pcw & ~reset;
  assign bus.IRWrite    = w_irw & ~reset;
  assign bus.MemWrite   = w_mw  & ~reset;
  assign bus.RegWrite   = w_rw  & ~reset;
  assign bus.AdrSrc     = w_adr;
  assign bus.ResultSrc  = w_rsrc;
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ImmSrc     = w_op;
  assign bus.RegSrc     = {(w_op == c_OP_MEM) & ~w_funct[0], (w_op == c_OP_B)};
  assign bus.ALUControl = ALU_CTRL_W'(w_alu);
  assign bus.Flags      = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_controller : directed instruction sequences against a sequencing model |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_mc_controller;
  localparam int INSTR_W = 16;
`ifdef MC_CTRL_CONDSKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NE = 4'h1, NV = 4'hF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_if #(.INSTR_W(INSTR_W), .ALU_CTRL_W(2)) bus ();
  mc_controller #(.INSTR_W(INSTR_W), .RD_LSB(0), .PC_REG(15), .ALU_CTRL_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic       pcw, irw, mw, rw;
    logic       adr, adr_chk;
    logic [1:0] rsrc;
    logic       rsrc_chk;
    logic [1:0] alu;
    logic       alu_chk;
    logic [3:0] flags;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  string      cur = "reset";
  logic [3:0] m_flags;
  int         cyc = 0, n_rw = 0, n_mw = 0, n_pcw = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", cur, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PCWrite",  32'(bus.PCWrite),  32'(e.pcw));
      chk("IRWrite",  32'(bus.IRWrite),  32'(e.irw));
      chk("MemWrite", 32'(bus.MemWrite), 32'(e.mw));
      chk("RegWrite", 32'(bus.RegWrite), 32'(e.rw));
      chk("Flags",    32'(bus.Flags),    32'(e.flags));
      if (e.adr_chk)  chk("AdrSrc",     32'(bus.AdrSrc),     32'(e.adr));
      if (e.rsrc_chk) chk("ResultSrc",  32'(bus.ResultSrc),  32'(e.rsrc));
      if (e.alu_chk)  chk("ALUControl", 32'(bus.ALUControl), 32'(e.alu));
    end
    if (bus.IRWrite === 1'b1) cyc = 1; else cyc++;
    n_rw  += int'(bus.RegWrite === 1'b1);
    n_mw  += int'(bus.MemWrite === 1'b1);
    n_pcw += int'(bus.PCWrite === 1'b1);
  end

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cf;           4'h3: return !cf;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cf && !z;     4'h9: return !cf || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t base();
    exp_t e = '0;
    e.flags = m_flags;
    return e;
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] r);
    return {c, o, f, r};
  endfunction

  function automatic logic [15:0] dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                                     input logic s, input logic [3:0] r);
    return mk(c, 2'b00, {i, cmd, s}, r);
  endfunction

  task automatic step(input logic mr, input exp_t e);
    bus.MemReady = mr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fstall);
    exp_t e;
    for (int i = 0; i <= fstall; i++) begin
      e = base();
      e.irw = (i == fstall);
      e.pcw = (i == fstall);
      e.adr_chk = 1'b1;
      e.rsrc = 2'b10; e.rsrc_chk = 1'b1;
      e.alu_chk = 1'b1;
      step(i == fstall, e);
    end
  endtask

  task automatic run(input string nm, input logic [15:0] ins, input logic [3:0] af,
                     input int fstall, input int mstall, input int exp_lat);
    logic [3:0] cond, cmd, rd;
    logic [1:0] op, alu;
    logic [5:0] fn;
    logic       c, dp_regw, arith, s_eff, rdpc;
    exp_t       e;
    {cond, op, fn, rd} = ins;
    cmd = fn[4:1];
    cur = nm;
    bus.Instr = ins;
    bus.ALUFlags = af;
    c = cond_pass(cond, m_flags);
    dp_regw = 1'b1; arith = 1'b0; alu = 2'b00; s_eff = fn[0];
    case (cmd)
      4'b0100: arith = 1'b1;
      4'b0010: begin alu = 2'b01; arith = 1'b1; end
      4'b0000: alu = 2'b10;
      4'b1100: alu = 2'b11;
      4'b1010: begin alu = 2'b01; arith = 1'b1; s_eff = 1'b1; dp_regw = 1'b0; end
      default: dp_regw = 1'b0;
    endcase
    rdpc = (rd == 4'd15);
    fetch(fstall);
    step(1'b1, base());
    if (!(SKIP && !c)) begin
      case (op)
        2'b00: begin
          e = base(); e.alu = alu; e.alu_chk = 1'b1;
          step(1'b1, e);
          if (c && s_eff) m_flags[3:2] = af[3:2];
          if (c && s_eff && arith) m_flags[1:0] = af[1:0];
          e = base(); e.rw = c & dp_regw; e.pcw = c & dp_regw & rdpc; e.rsrc_chk = 1'b1;
          step(1'b1, e);
        end
        2'b01: begin
          e = base(); e.alu_chk = 1'b1;
          step(1'b1, e);
          for (int i = 0; i <= mstall; i++) begin
            e = base(); e.adr = 1'b1; e.adr_chk = 1'b1;
            e.mw = !fn[0] && c && (i == mstall);
            step(i == mstall, e);
          end
          if (fn[0]) begin
            e = base(); e.rw = c; e.pcw = c & rdpc; e.rsrc = 2'b01; e.rsrc_chk = 1'b1;
            step(1'b1, e);
          end
        end
        2'b10: begin
          e = base(); e.pcw = c; e.rsrc = 2'b10; e.rsrc_chk = 1'b1; e.alu_chk = 1'b1;
          step(1'b1, e);
        end
        default: ;
      endcase
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    int   rw0, mw0, pw0;
    exp_t e;
    reset = 1'b1;
    bus.Instr = mk(AL, 2'b11, 6'h0, 4'h0);
    bus.ALUFlags = 4'h0;
    bus.MemReady = 1'b1;
    m_flags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) step(1'b1, base());
    chk("reset_flags", 32'(bus.Flags), 32'h0);
    reset = 1'b0;

    run("add_s_z0", dp(AL, 1'b0, 4'b0100, 1'b1, 4'd1), 4'b0000, 0, 0, 4);
    pw0 = n_pcw;
    run("beq_fail", mk(EQ, 2'b10, 6'h0, 4'd0), 4'h0, 0, 0, SKIP ? 2 : 3);
    chk("beq_fail_pcw", 32'(n_pcw - pw0), 32'd1);
    run("add_s_z1", dp(AL, 1'b0, 4'b0100, 1'b1, 4'd1), 4'b0100, 0, 0, 4);
    chk("add_flags", 32'(bus.Flags), 32'h4);
    pw0 = n_pcw;
    run("beq_pass", mk(EQ, 2'b10, 6'h0, 4'd0), 4'h0, 0, 0, 3);
    chk("beq_pass_pcw", 32'(n_pcw - pw0), 32'd2);
    rw0 = n_rw;
    run("ldr_stall", mk(AL, 2'b01, 6'b000001, 4'd2), 4'h0, 0, 3, 8);
    chk("ldr_regw", 32'(n_rw - rw0), 32'd1);
    run("orr_imm_s", dp(AL, 1'b1, 4'b1100, 1'b1, 4'd5), 4'b1011, 0, 0, 4);
    chk("orr_flags", 32'(bus.Flags), 32'h8);
    rw0 = n_rw;
    run("cmp", dp(AL, 1'b0, 4'b1010, 1'b0, 4'd0), 4'b0100, 0, 0, 4);
    chk("cmp_flags", 32'(bus.Flags), 32'h4);
    chk("cmp_regw", 32'(n_rw - rw0), 32'd0);
    rw0 = n_rw;
    run("addeq", dp(EQ, 1'b0, 4'b0100, 1'b0, 4'd3), 4'hF, 0, 0, 4);
    chk("addeq_regw", 32'(n_rw - rw0), 32'd1);
    rw0 = n_rw;
    run("addne_s", dp(NE, 1'b0, 4'b0100, 1'b1, 4'd3), 4'hF, 0, 0, SKIP ? 2 : 4);
    chk("addne_regw", 32'(n_rw - rw0), 32'd0);
    chk("addne_flags", 32'(bus.Flags), 32'h4);
    run("sub_s", dp(AL, 1'b0, 4'b0010, 1'b1, 4'd6), 4'b0011, 0, 0, 4);
    chk("sub_flags", 32'(bus.Flags), 32'h3);
    run("and", dp(AL, 1'b0, 4'b0000, 1'b0, 4'd7), 4'hF, 0, 0, 4);
    mw0 = n_mw;
    run("str", mk(AL, 2'b01, 6'h0, 4'd4), 4'h0, 0, 2, 6);
    chk("str_memw", 32'(n_mw - mw0), 32'd1);
    mw0 = n_mw;
    run("str_nv", mk(NV, 2'b01, 6'h0, 4'd4), 4'h0, 0, 1, SKIP ? 2 : 5);
    chk("str_nv_memw", 32'(n_mw - mw0), 32'd0);
    pw0 = n_pcw;
    run("add_pc", dp(AL, 1'b0, 4'b0100, 1'b0, 4'd15), 4'h0, 0, 0, 4);
    chk("add_pc_pcw", 32'(n_pcw - pw0), 32'd2);
    rw0 = n_rw;
    run("eor_s", dp(AL, 1'b0, 4'b0001, 1'b1, 4'd8), 4'b1100, 0, 0, 4);
    chk("eor_flags", 32'(bus.Flags), 32'hF);
    chk("eor_regw", 32'(n_rw - rw0), 32'd0);
    run("nop", mk(AL, 2'b11, 6'h0, 4'd0), 4'h0, 0, 0, 2);
    run("add_fstall", dp(AL, 1'b0, 4'b0100, 1'b0, 4'd9), 4'h0, 2, 0, 4);
    pw0 = n_pcw;
    run("ldr_pc", mk(AL, 2'b01, 6'b000001, 4'd15), 4'h0, 0, 0, 5);
    chk("ldr_pc_pcw", 32'(n_pcw - pw0), 32'd2);

    cur = "reset_memwr";
    mw0 = n_mw;
    bus.Instr = mk(AL, 2'b01, 6'h0, 4'd4);
    fetch(0);
    step(1'b1, base());
    e = base(); e.alu_chk = 1'b1;
    step(1'b1, e);
    reset = 1'b1;
    step(1'b1, base());
    reset = 1'b0;
    m_flags = 4'h0;
    chk("flags_after_reset", 32'(bus.Flags), 32'h0);
    run("nop_after_reset", mk(AL, 2'b11, 6'h0, 4'd0), 4'h0, 0, 0, 2);
    chk("reset_memw", 32'(n_mw - mw0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
